lru_tag_ctrl: RTL and testbench
===============================

# lru_tag_ctrl

Fully-associative tag controller that sequences an `lru` replacement tracker. It accepts lookup and invalidate requests carrying a tag, compares them against a NUM_WAYS-entry tag array, and issues the matching touch, allocate or invalidate operation to the tracker. On a miss with all ways valid it emits the displaced tag on an eviction channel before responding. It sits between a requesting load/store pipe and the way-state storage of a small cache or buffer.

## Interface
Parameters:
- NUM_WAYS, 4, number of ways; power of two, ≥2
- TAG_W, 16, tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_op_i  in  2  2'b01 lookup, 2'b11 invalidate; 2'b00/2'b10 illegal
- req_tag_i  in  TAG_W  request tag
- rsp_valid_o  out  1  response valid, held until rsp_ready_i
- rsp_ready_i  in  1  response consumed
- rsp_hit_o  out  1  tag was present at lookup time
- rsp_way_o  out  $clog2(NUM_WAYS)  way hit, allocated or invalidated
- evict_valid_o  out  1  eviction valid, held until evict_ready_i
- evict_ready_i  in  1  eviction consumed
- evict_tag_o  out  TAG_W  tag displaced by allocation

## Operation
- State: tag_q[NUM_WAYS], vld_q[NUM_WAYS], captured op/tag, victim way, FSM.
- FSM states:
  - IDLE:
    - req_ready_o=1.
    - On handshake: capture op/tag, go to LOOKUP.
  - LOOKUP:
    - Parallel compare tag_q[w]==tag & vld_q[w].
    - Lookup hit: drive LRU op 01 on the hit way; go to RESP with hit=1.
    - Lookup miss: drive LRU op 10, which returns a one-hot victim combinationally. Encode it to a way index. Write tag_q[victim]=tag and set vld_q[victim].
      - If vld_q[victim] was already 1: latch the old tag and go to EVICT.
      - Otherwise: go to RESP with hit=0.
    - Invalidate hit: drive LRU op 11 on the way, clear vld_q; go to RESP with hit=1.
    - Invalidate miss: no LRU op; go to RESP with hit=0, way=0.
    - Illegal op: no LRU op, no state change; go to RESP with hit=0, way=0.
  - EVICT:
    - evict_valid_o=1, evict_tag_o stable.
    - On evict_ready_i, go to RESP.
  - RESP:
    - rsp_valid_o=1, rsp_hit_o/rsp_way_o stable.
    - On rsp_ready_i, go to IDLE.
- Exactly one LRU operation per request, always in the LOOKUP cycle.
- The controller keeps vld_q identical to the tracker's availability: allocation sets a way, invalidation frees it.
- Duplicate valid tags are impossible by construction. Allocation picks the lowest-index invalid way first, otherwise the least-recently touched way.
- Hit way index is a priority encode of the match vector (lowest index).

## Timing
- Reset values:
  - state IDLE, vld_q all 0.
  - req_ready_o=0 while reset is high; rsp_valid_o, evict_valid_o = 0.
  - rsp_hit_o, rsp_way_o, evict_tag_o = 0.
  - Tag array contents are don't-care.
- Request accepted at cycle T → LOOKUP at T+1 → RESP or EVICT visible at T+2.
- Eviction path: rsp_valid_o rises the cycle after the evict handshake.
- Single outstanding request. req_ready_o stays 0 from T+1 until the cycle after the rsp handshake.
- Outputs are registered and held unchanged under backpressure. evict_ready_i and rsp_ready_i may be tied high.
- rsp_ready_i is ignored outside RESP; evict_ready_i is ignored outside EVICT.
- Reset in any state takes effect next edge:
  - Any pending evict or response is dropped.
  - No partial update survives, because vld_q clears.
  - The lru instance receives the same reset.

## Structure
- Package lru_pkg holds:
  - Request op encodings REQ_LOOKUP=2'b01, REQ_INVAL=2'b11.
  - LRU op encodings OP_LOAD/OP_STORE/OP_INVALIDATE.
  - FSM state enum {IDLE, LOOKUP, EVICT, RESP}.
- One sub-module: `lru` #(NUM_WAYS), instantiated once. Its ls_* inputs are driven only in LOOKUP.
- The one-hot-to-index encoder and the tag compare are inline logic.

## Test plan
- Reset, then lookups 0x000A, 0x000B, 0x000C, 0x000D → each miss (hit=0) on ways 0,1,2,3 respectively, no evict_valid_o, rsp_valid_o at T+2.
- Then lookup 0x000A → hit=1 way 0; then lookup 0x000E → evict_tag_o=0x000B, then rsp hit=0 way 1.
- Invalidate 0x000C → hit=1 way 2; then lookup 0x000F → miss way 2 with no eviction; then invalidate 0x0099 → hit=0 way 0, no LRU op.
- Evict backpressure: hold evict_ready_i=0 for 5 cycles → evict_valid_o/evict_tag_o stable, req_ready_o=0, rsp_valid_o only the cycle after the handshake.
- Response backpressure: hold rsp_ready_i=0 for 4 cycles with req_valid_i=1 → no second acceptance, rsp fields stable.
- Assert reset while in EVICT → next cycle evict_valid_o=0, rsp_valid_o=0; the following lookup 0x0001 allocates way 0 with hit=0.

Source files
------------

// File: rtl/lru_pkg.sv
// lru_pkg: request/LRU op encodings and controller FSM states.
package lru_pkg;
   localparam logic [1:0] REQ_LOOKUP    = 2'b01;
   localparam logic [1:0] REQ_INVAL     = 2'b11;
   localparam logic [1:0] OP_LOAD       = 2'b01;
   localparam logic [1:0] OP_STORE      = 2'b10;
   localparam logic [1:0] OP_INVALIDATE = 2'b11;
   typedef enum logic [1:0] {IDLE, LOOKUP, EVICT, RESP} state_t;
endpackage

// File: rtl/lru.sv
// lru: per-way availability plus age-ordered replacement; victim is lowest free way, else oldest.
module lru
   import lru_pkg::*;
#(
   parameter int NUM_WAYS = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ls_valid_i,
   input  logic [1:0]                  ls_op_i,
   input  logic [$clog2(NUM_WAYS)-1:0] ls_way_i,
   output logic [NUM_WAYS-1:0]         victim_o
);
   localparam int WAY_W = $clog2(NUM_WAYS);
   logic [NUM_WAYS-1:0] r_avail;
   logic [WAY_W-1:0]    r_age [NUM_WAYS];
   logic [WAY_W-1:0]    w_victim_way;
   logic [WAY_W-1:0]    w_touch_way;
   logic                w_touch;
   // Ages form a permutation of 0..NUM_WAYS-1; the oldest way holds NUM_WAYS-1.
   always_comb begin
      w_victim_way = '0;
      victim_o     = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if ((&r_avail) ? (r_age[w] == WAY_W'(NUM_WAYS - 1)) : !r_avail[w]) w_victim_way = WAY_W'(w);
      victim_o[w_victim_way] = 1'b1;
      w_touch     = ls_valid_i && (ls_op_i == OP_LOAD || ls_op_i == OP_STORE);
      w_touch_way = (ls_op_i == OP_STORE) ? w_victim_way : ls_way_i;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_avail <= '0;
         for (int w = 0; w < NUM_WAYS; w++) r_age[w] <= WAY_W'(w);
      end else begin
         if (ls_valid_i && ls_op_i == OP_STORE) r_avail[w_victim_way] <= 1'b1;
         if (ls_valid_i && ls_op_i == OP_INVALIDATE) r_avail[ls_way_i] <= 1'b0;
         if (w_touch)
            for (int w = 0; w < NUM_WAYS; w++)
               r_age[w] <= (WAY_W'(w) == w_touch_way) ? '0 :
                           (r_age[w] < r_age[w_touch_way]) ? r_age[w] + 1'b1 : r_age[w];
      end
   end
endmodule

// File: rtl/lru_tag_ctrl.sv
// lru_tag_ctrl: fully-associative tag array sequencing one lru operation per request,
// with an eviction channel ahead of the response when a valid way is displaced.
module lru_tag_ctrl
   import lru_pkg::*;
#(
   parameter int NUM_WAYS = 4,
   parameter int TAG_W    = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [1:0]                  req_op_i,
   input  logic [TAG_W-1:0]            req_tag_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic                        rsp_hit_o,
   output logic [$clog2(NUM_WAYS)-1:0] rsp_way_o,
   output logic                        evict_valid_o,
   input  logic                        evict_ready_i,
   output logic [TAG_W-1:0]            evict_tag_o
);
   localparam int WAY_W = $clog2(NUM_WAYS);
   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_op;
   logic [TAG_W-1:0]    r_tag;
   logic [TAG_W-1:0]    r_tags [NUM_WAYS];
   logic [NUM_WAYS-1:0] r_vld;
   logic                r_hit;
   logic [WAY_W-1:0]    r_way;
   logic [TAG_W-1:0]    r_evict_tag;
   logic [NUM_WAYS-1:0] w_match;
   logic [NUM_WAYS-1:0] w_victim;
   logic [WAY_W-1:0]    w_hit_way;
   logic [WAY_W-1:0]    w_victim_way;
   logic                w_hit;
   logic                w_is_lookup;
   logic                w_is_inval;
   logic                w_evict;
   logic                w_ls_valid;
   logic [1:0]          w_ls_op;
   always_comb begin
      w_hit_way    = '0;
      w_victim_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) w_match[w] = r_vld[w] && (r_tags[w] == r_tag);
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (w_match[w]) w_hit_way = WAY_W'(w);
         if (w_victim[w]) w_victim_way = WAY_W'(w);
      end
      w_hit       = |w_match;
      w_is_lookup = r_op == REQ_LOOKUP;
      w_is_inval  = r_op == REQ_INVAL;
      w_evict     = w_is_lookup && !w_hit && r_vld[w_victim_way];
      w_ls_valid  = (r_state == LOOKUP) && (w_is_lookup || (w_is_inval && w_hit));
      w_ls_op     = w_is_lookup ? (w_hit ? OP_LOAD : OP_STORE) : OP_INVALIDATE;
      w_next = (r_state == IDLE)   ? (req_valid_i ? LOOKUP : IDLE) :
               (r_state == LOOKUP) ? (w_evict ? EVICT : RESP) :
               (r_state == EVICT)  ? (evict_ready_i ? RESP : EVICT) :
                                     (rsp_ready_i ? IDLE : RESP);
   end
   lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .clk       (clk),
      .reset     (reset),
      .ls_valid_i(w_ls_valid),
      .ls_op_i   (w_ls_op),
      .ls_way_i  (w_hit_way),
      .victim_o  (w_victim)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_op        <= '0;
         r_tag       <= '0;
         r_vld       <= '0;
         r_hit       <= 1'b0;
         r_way       <= '0;
         r_evict_tag <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && req_valid_i) begin
            r_op  <= req_op_i;
            r_tag <= req_tag_i;
         end
         if (r_state == LOOKUP) begin
            r_hit <= (w_is_lookup || w_is_inval) && w_hit;
            r_way <= w_is_lookup ? (w_hit ? w_hit_way : w_victim_way) : (w_is_inval && w_hit) ? w_hit_way : '0;
            if (w_is_lookup && !w_hit) begin
               r_tags[w_victim_way] <= r_tag;
               r_vld[w_victim_way]  <= 1'b1;
               if (r_vld[w_victim_way]) r_evict_tag <= r_tags[w_victim_way];
            end
            if (w_is_inval && w_hit) r_vld[w_hit_way] <= 1'b0;
         end
      end
   end
   assign req_ready_o   = (r_state == IDLE) && !reset;
   assign rsp_valid_o   = r_state == RESP;
   assign evict_valid_o = r_state == EVICT;
   assign rsp_hit_o     = r_hit;
   assign rsp_way_o     = r_way;
   assign evict_tag_o   = r_evict_tag;
endmodule

// File: tb/tb_lru_tag_ctrl.sv
// tb_lru_tag_ctrl: directed vector table plus hand-written backpressure and reset sequences.
module tb_lru_tag_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid_i, req_ready_o;
   logic [1:0]  req_op_i;
   logic [15:0] req_tag_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_hit_o;
   logic [1:0]  rsp_way_o;
   logic        evict_valid_o, evict_ready_i;
   logic [15:0] evict_tag_o;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] tag;
      logic        hit;
      logic [1:0]  way;
      logic        ev;
      logic [15:0] ev_tag;
   } vec_t;
   vec_t vecs [11];

   always #5 clk = ~clk;

   lru_tag_ctrl #(.NUM_WAYS(4), .TAG_W(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_tag_i(req_tag_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_hit_o(rsp_hit_o), .rsp_way_o(rsp_way_o),
      .evict_valid_o(evict_valid_o), .evict_ready_i(evict_ready_i),
      .evict_tag_o(evict_tag_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request at a negedge; returns at the negedge where the response (or eviction) is visible.
   task automatic issue(input logic [1:0] op, input logic [15:0] tag);
      chk("req_ready_idle", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1;
      req_op_i    = op;
      req_tag_i   = tag;
      @(negedge clk);
      req_valid_i = 1'b0;
      chk("lookup_req_ready", 32'(req_ready_o), 32'd0);
      chk("lookup_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("lookup_evict_valid", 32'(evict_valid_o), 32'd0);
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      issue(v.op, v.tag);
      if (v.ev) begin
         chk("evict_valid", 32'(evict_valid_o), 32'd1);
         chk("evict_tag", 32'(evict_tag_o), 32'(v.ev_tag));
         chk("evict_rsp_valid", 32'(rsp_valid_o), 32'd0);
         @(negedge clk);
      end else
         chk("no_evict", 32'(evict_valid_o), 32'd0);
      chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("rsp_hit", 32'(rsp_hit_o), 32'(v.hit));
      chk("rsp_way", 32'(rsp_way_o), 32'(v.way));
      @(negedge clk);
      chk("rsp_done", 32'(rsp_valid_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{2'b01, 16'h000A, 1'b0, 2'd0, 1'b0, 16'h0000};
      vecs[1]  = '{2'b01, 16'h000B, 1'b0, 2'd1, 1'b0, 16'h0000};
      vecs[2]  = '{2'b01, 16'h000C, 1'b0, 2'd2, 1'b0, 16'h0000};
      vecs[3]  = '{2'b01, 16'h000D, 1'b0, 2'd3, 1'b0, 16'h0000};
      vecs[4]  = '{2'b01, 16'h000A, 1'b1, 2'd0, 1'b0, 16'h0000};
      vecs[5]  = '{2'b01, 16'h000E, 1'b0, 2'd1, 1'b1, 16'h000B};
      vecs[6]  = '{2'b11, 16'h000C, 1'b1, 2'd2, 1'b0, 16'h0000};
      vecs[7]  = '{2'b01, 16'h000F, 1'b0, 2'd2, 1'b0, 16'h0000};
      vecs[8]  = '{2'b11, 16'h0099, 1'b0, 2'd0, 1'b0, 16'h0000};
      vecs[9]  = '{2'b00, 16'h000A, 1'b0, 2'd0, 1'b0, 16'h0000};
      vecs[10] = '{2'b10, 16'h000F, 1'b0, 2'd0, 1'b0, 16'h0000};
      reset = 1'b1;
      req_valid_i = 1'b0;
      req_op_i = 2'b00;
      req_tag_i = '0;
      rsp_ready_i = 1'b1;
      evict_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready_o), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("reset_evict_valid", 32'(evict_valid_o), 32'd0);
      chk("reset_rsp_hit", 32'(rsp_hit_o), 32'd0);
      chk("reset_rsp_way", 32'(rsp_way_o), 32'd0);
      chk("reset_evict_tag", 32'(evict_tag_o), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 11; i++) run_vec(vecs[i]);
      // Ways now A,E,F,D; D is oldest, so 0x0010 displaces it under evict backpressure.
      evict_ready_i = 1'b0;
      issue(2'b01, 16'h0010);
      for (int i = 0; i < 5; i++) begin
         chk("evbp_valid", 32'(evict_valid_o), 32'd1);
         chk("evbp_tag", 32'(evict_tag_o), 32'h000D);
         chk("evbp_req_ready", 32'(req_ready_o), 32'd0);
         chk("evbp_rsp_valid", 32'(rsp_valid_o), 32'd0);
         @(negedge clk);
      end
      evict_ready_i = 1'b1;
      @(negedge clk);
      chk("evbp_evict_done", 32'(evict_valid_o), 32'd0);
      chk("evbp_rsp_valid_after", 32'(rsp_valid_o), 32'd1);
      chk("evbp_rsp_hit", 32'(rsp_hit_o), 32'd0);
      chk("evbp_rsp_way", 32'(rsp_way_o), 32'd3);
      @(negedge clk);
      // Response backpressure with a second request waiting.
      rsp_ready_i = 1'b0;
      issue(2'b01, 16'h000A);
      req_valid_i = 1'b1;
      req_tag_i = 16'h0055;
      for (int i = 0; i < 4; i++) begin
         chk("rspbp_valid", 32'(rsp_valid_o), 32'd1);
         chk("rspbp_hit", 32'(rsp_hit_o), 32'd1);
         chk("rspbp_way", 32'(rsp_way_o), 32'd0);
         chk("rspbp_req_ready", 32'(req_ready_o), 32'd0);
         @(negedge clk);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      chk("rspbp_done", 32'(rsp_valid_o), 32'd0);
      chk("rspbp_idle_ready", 32'(req_ready_o), 32'd1);
      // Oldest way is now 1 (tag E); reset while that eviction is pending.
      evict_ready_i = 1'b0;
      issue(2'b01, 16'h0020);
      chk("rst_evict_valid_pre", 32'(evict_valid_o), 32'd1);
      chk("rst_evict_tag_pre", 32'(evict_tag_o), 32'h000E);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_evict_valid", 32'(evict_valid_o), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      reset = 1'b0;
      evict_ready_i = 1'b1;
      @(negedge clk);
      run_vec('{2'b01, 16'h0001, 1'b0, 2'd0, 1'b0, 16'h0000});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
